// File: rtl/alarm_audio_pkg.sv
// Shared types and melody tables for the alarm tone sequencer.
package alarm_audio_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitWr,
    StWrite,
    StGapWait,
    StGapWrite
  } state_e;

  // Eight melody steps, each a 3-bit note ROM index; element 0 plays first.
  typedef logic [7:0][2:0] melody_t;

  localparam melody_t PATTERN_6NOTE = {3'd2, 3'd4, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam melody_t PATTERN_2NOTE = {3'd5, 3'd5, 3'd2, 3'd2, 3'd5, 3'd5, 3'd2, 3'd2};
  localparam logic [2:0] NOTE_REST = 3'd7;

  function automatic logic [2:0] melody_note(input logic pat, input logic [2:0] step);
    melody_t m;
    m = pat ? PATTERN_2NOTE : PATTERN_6NOTE;
    return m[step];
  endfunction

endpackage

// File: rtl/alarm_tone_sequencer_if.sv
// CODEC write/read handshake between the sequencer (master) and audio_codec (slave).
interface alarm_tone_sequencer_if #(
  parameter int unsigned DATA_W = 24
);
  logic              read_ready;
  logic              write_ready;
  logic              codec_write;
  logic              codec_read;
  logic [DATA_W-1:0] sample_out;

  modport master (
    input  read_ready, write_ready,
    output codec_write, codec_read, sample_out
  );

  modport slave (
    output read_ready, write_ready,
    input  codec_write, codec_read, sample_out
  );
endinterface

// File: rtl/sample_counter.sv
// Terminal-count counter: counts inc_i pulses, flags the Limit-th one and clears itself.
module sample_counter #(
  parameter int unsigned Limit = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic done_o
);
  localparam int unsigned Width = $clog2(Limit + 1);

  logic [Width-1:0] cnt_q, cnt_d;

  assign done_o = inc_i && (cnt_q == Width'(Limit - 1));

  // Next count: clear has priority, terminal count wraps back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || done_o) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  // Count register, synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/alarm_tone_sequencer.sv
// Plays a melody from the note ROMs into the CODEC DAC, one strobe per handshake.
module alarm_tone_sequencer
  import alarm_audio_pkg::*;
#(
  parameter int unsigned NUM_NOTES    = 6,
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned DATA_W       = 24,
  parameter int unsigned ROM_LAT      = 2,
  parameter int unsigned NOTE_SAMPLES = 12000,
  parameter int unsigned GAP_SAMPLES  = 2400
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        pattern_sel,
  input  logic [NUM_NOTES*DATA_W-1:0] rom_q,
  output logic [ADDR_W-1:0]           rom_addr,
  output logic [2:0]                  note_idx,
  output logic                        busy,
  alarm_tone_sequencer_if.master      codec
);
  localparam int unsigned LatW = $clog2(ROM_LAT + 1);

  state_e            state_q, state_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic [2:0]        step_q, step_d;
  logic              pat_q, pat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [2:0]        note_q, note_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              note_done, gap_done, rdy;
  logic [2:0]        cur_note;

  assign rdy      = codec.read_ready && codec.write_ready;
  assign cur_note = melody_note(pat_q, step_q);

  sample_counter #(.Limit(NOTE_SAMPLES)) u_note_cnt (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .clr_i  (!enable),
    .inc_i  (state_q == StWrite),
    .done_o (note_done)
  );

  sample_counter #(.Limit(GAP_SAMPLES)) u_gap_cnt (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .clr_i  (!enable),
    .inc_i  (state_q == StGapWrite),
    .done_o (gap_done)
  );

  // Next-state logic plus the next values of every registered output.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    step_d   = step_q;
    pat_d    = pat_q;
    addr_d   = addr_q;
    sample_d = sample_q;
    unique case (state_q)
      StIdle: begin
        addr_d   = '0;
        sample_d = '0;
        step_d   = '0;
        lat_d    = '0;
        if (enable) begin
          pat_d   = pattern_sel;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (lat_q == LatW'(ROM_LAT - 1)) begin
          lat_d    = '0;
          sample_d = rom_q[int'(cur_note)*DATA_W +: DATA_W];
          state_d  = StWaitWr;
        end else begin
          lat_d = lat_q + LatW'(1);
        end
      end
      StWaitWr: begin
        if (rdy) state_d = StWrite;
      end
      StWrite: begin
        addr_d = addr_q + ADDR_W'(1);
        if (note_done) begin
          sample_d = '0;
          state_d  = StGapWait;
        end else begin
          state_d = StFetch;
        end
      end
      StGapWait: begin
        // Gap writes are paced like note writes so strobe spacing never shrinks.
        if (lat_q != LatW'(ROM_LAT)) begin
          lat_d = lat_q + LatW'(1);
        end else if (rdy) begin
          lat_d   = '0;
          state_d = StGapWrite;
        end
      end
      StGapWrite: begin
        if (gap_done) begin
          step_d  = step_q + 3'd1;
          addr_d  = '0;
          if (step_q == 3'd7) pat_d = pattern_sel;
          state_d = StFetch;
        end else begin
          state_d = StGapWait;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!enable) begin
      state_d  = StIdle;
      lat_d    = '0;
      step_d   = '0;
      addr_d   = '0;
      sample_d = '0;
    end

    note_d = (state_d inside {StFetch, StWaitWr, StWrite}) ? melody_note(pat_d, step_d)
                                                           : NOTE_REST;
    wr_d   = (state_d inside {StWrite, StGapWrite});
    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset wins over any pending strobe.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= StIdle;
      lat_q    <= '0;
      step_q   <= '0;
      pat_q    <= 1'b0;
      addr_q   <= '0;
      sample_q <= '0;
      note_q   <= NOTE_REST;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      step_q   <= step_d;
      pat_q    <= pat_d;
      addr_q   <= addr_d;
      sample_q <= sample_d;
      note_q   <= note_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
    end
  end

  assign rom_addr          = addr_q;
  assign note_idx          = note_q;
  assign busy              = busy_q;
  assign codec.codec_write = wr_q;
  assign codec.codec_read  = wr_q;
  assign codec.sample_out  = sample_q;
endmodule
